// File: rtl/fp_compare_pipe.sv
// Two-stage streaming comparator for sign-magnitude floats with max/min select.
// Optional saturating greater-than counter when FP_CMP_STATS_EN is defined.
module fp_compare_pipe #(
  parameter int unsigned EXP_W = 4,
  parameter int unsigned MAN_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef FP_CMP_STATS_EN
  input  logic                   stat_clear,
  output logic [15:0]            stat_gt_count,
`endif
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic                   in_sel_min,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_gt,
  output logic                   out_eq,
  output logic                   out_lt,
  output logic [EXP_W+MAN_W:0]   out_value
);

  localparam int unsigned W     = 1 + EXP_W + MAN_W;
  localparam int unsigned MAG_W = EXP_W + MAN_W;

  // Stage 1: operands plus pre-computed sign/magnitude relations
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d;
  logic [W-1:0]     s1_b_q, s1_b_d;
  logic             s1_sel_min_q, s1_sel_min_d;
  logic             s1_sign_a_q, s1_sign_a_d;
  logic             s1_sign_b_q, s1_sign_b_d;
  logic             s1_mag_gt_q, s1_mag_gt_d;
  logic             s1_mag_eq_q, s1_mag_eq_d;
  logic             s1_zero_a_q, s1_zero_a_d;
  logic             s1_zero_b_q, s1_zero_b_d;

  // Stage 2: final flags and selected operand
  logic             s2_valid_q, s2_valid_d;
  logic             s2_gt_q, s2_gt_d;
  logic             s2_eq_q, s2_eq_d;
  logic             s2_lt_q, s2_lt_d;
  logic [W-1:0]     s2_value_q, s2_value_d;

  logic             s1_ready;
  logic             s2_ready;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             take_b;
  logic [MAG_W-1:0] mag_a;
  logic [MAG_W-1:0] mag_b;

`ifdef FP_CMP_STATS_EN
  logic [15:0]      stat_cnt_q, stat_cnt_d;
`endif

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_a_d       = s1_a_q;
    s1_b_d       = s1_b_q;
    s1_sel_min_d = s1_sel_min_q;
    s1_sign_a_d  = s1_sign_a_q;
    s1_sign_b_d  = s1_sign_b_q;
    s1_mag_gt_d  = s1_mag_gt_q;
    s1_mag_eq_d  = s1_mag_eq_q;
    s1_zero_a_d  = s1_zero_a_q;
    s1_zero_b_d  = s1_zero_b_q;
    s2_valid_d   = s2_valid_q;
    s2_gt_d      = s2_gt_q;
    s2_eq_d      = s2_eq_q;
    s2_lt_d      = s2_lt_q;
    s2_value_d   = s2_value_q;
    cmp_gt       = 1'b0;
    cmp_eq       = 1'b0;
    cmp_lt       = 1'b0;
    take_b       = 1'b0;
    mag_a        = in_a[MAG_W-1:0];
    mag_b        = in_b[MAG_W-1:0];

    s2_ready = !s2_valid_q || out_ready;
    s1_ready = !s1_valid_q || s2_ready;

    if (s1_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d       = in_a;
        s1_b_d       = in_b;
        s1_sel_min_d = in_sel_min;
        s1_sign_a_d  = in_a[W-1];
        s1_sign_b_d  = in_b[W-1];
        s1_mag_gt_d  = mag_a > mag_b;
        s1_mag_eq_d  = mag_a == mag_b;
        s1_zero_a_d  = mag_a == '0;
        s1_zero_b_d  = mag_b == '0;
      end
    end

    // Zero check first so that +0 and -0 tie regardless of sign bits
    if (s1_zero_a_q && s1_zero_b_q) begin
      cmp_eq = 1'b1;
    end else if (s1_sign_a_q != s1_sign_b_q) begin
      cmp_gt = !s1_sign_a_q;
      cmp_lt = s1_sign_a_q;
    end else if (s1_mag_eq_q) begin
      cmp_eq = 1'b1;
    end else if (s1_sign_a_q) begin
      cmp_gt = !s1_mag_gt_q;
      cmp_lt = s1_mag_gt_q;
    end else begin
      cmp_gt = s1_mag_gt_q;
      cmp_lt = !s1_mag_gt_q;
    end

    take_b = s1_sel_min_q ? cmp_gt : cmp_lt;

    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_gt_d    = cmp_gt;
        s2_eq_d    = cmp_eq;
        s2_lt_d    = cmp_lt;
        s2_value_d = take_b ? s1_b_q : s1_a_q;
      end
    end

`ifdef FP_CMP_STATS_EN
    stat_cnt_d = stat_cnt_q;
    if (stat_clear) begin
      stat_cnt_d = 16'h0000;
    end else if (s2_valid_q && out_ready && s2_gt_q && (stat_cnt_q != 16'hFFFF)) begin
      stat_cnt_d = stat_cnt_q + 16'd1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_sel_min_q <= 1'b0;
      s1_sign_a_q  <= 1'b0;
      s1_sign_b_q  <= 1'b0;
      s1_mag_gt_q  <= 1'b0;
      s1_mag_eq_q  <= 1'b0;
      s1_zero_a_q  <= 1'b0;
      s1_zero_b_q  <= 1'b0;
      s2_valid_q   <= 1'b0;
      s2_gt_q      <= 1'b0;
      s2_eq_q      <= 1'b0;
      s2_lt_q      <= 1'b0;
      s2_value_q   <= '0;
`ifdef FP_CMP_STATS_EN
      stat_cnt_q   <= 16'h0000;
`endif
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_sel_min_q <= s1_sel_min_d;
      s1_sign_a_q  <= s1_sign_a_d;
      s1_sign_b_q  <= s1_sign_b_d;
      s1_mag_gt_q  <= s1_mag_gt_d;
      s1_mag_eq_q  <= s1_mag_eq_d;
      s1_zero_a_q  <= s1_zero_a_d;
      s1_zero_b_q  <= s1_zero_b_d;
      s2_valid_q   <= s2_valid_d;
      s2_gt_q      <= s2_gt_d;
      s2_eq_q      <= s2_eq_d;
      s2_lt_q      <= s2_lt_d;
      s2_value_q   <= s2_value_d;
`ifdef FP_CMP_STATS_EN
      stat_cnt_q   <= stat_cnt_d;
`endif
    end
  end

  assign in_ready  = s1_ready;
  assign out_valid = s2_valid_q;
  assign out_gt    = s2_gt_q;
  assign out_eq    = s2_eq_q;
  assign out_lt    = s2_lt_q;
  assign out_value = s2_value_q;
`ifdef FP_CMP_STATS_EN
  assign stat_gt_count = stat_cnt_q;
`endif

endmodule

// File: doc/fp_compare_pipe.md
Name: fp_compare_pipe

Overview:
- Parametrised, pipelined comparator for sign-magnitude floating-point values (sign, biased exponent, mantissa).
- Streaming datapath with valid/ready handshake; 2-stage pipeline.
- Outputs gt/eq/lt flags and the selected max or min operand per transaction.
- Sits between operand producers and sort/threshold logic; generalises the fixed 13-bit greater-than comparator to any field width, adds ±0 equality, operand select and backpressure.

Parameters:
- EXP_W, 4, exponent field width in bits (≥1).
- MAN_W, 8, mantissa field width in bits (≥1).
- W (localparam), 1+EXP_W+MAN_W, operand width. Layout: [W-1] sign, [W-2:MAN_W] exponent, [MAN_W-1:0] mantissa.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block accepts pair this cycle
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_sel_min  input  1  0: out_value = max(A,B); 1: out_value = min(A,B)
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_gt  output  1  A > B
- out_eq  output  1  A == B
- out_lt  output  1  A < B
- out_value  output  W  selected operand, bit-exact copy of A or B

Behaviour:
- Transfer occurs on any cycle with valid && ready (both ports).
- Magnitude: unsigned {exponent, mantissa}. No special meaning for all-ones exponent (no NaN/Inf). Denormals compare as plain magnitudes.
- Zero: magnitude == 0. +0 and -0 compare equal.
- Compare rules:
  - Both zero → eq.
  - Signs differ → positive operand greater.
  - Both positive → larger magnitude greater.
  - Both negative → smaller magnitude greater.
  - Equal sign and magnitude → eq.
- Exactly one of gt/eq/lt is 1 whenever out_valid=1.
- Select: max → B if lt else A; min → B if gt else A. Ties (incl. ±0) return A unchanged, sign bit preserved.
- Pipeline:
  - S1 registers operands, sel_min, sign compare, magnitude compare (mag_gt, mag_eq), zero detect.
  - S2 registers final flags and out_value.
  - Latency: accepted at edge N → out_valid at edge N+2 if unstalled.
- Ready chain:
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready (combinational from out_ready, no internal bubble)
  - Full throughput: 1 result/cycle.
- Stall: out_ready=0 with out_valid=1 holds out_* stable. Up to 2 pairs buffered, then in_ready=0. Data must not change while held.
- Reset (rst_n=0 at edge): s1_valid=s2_valid=0 → out_valid=0, out_gt=out_eq=out_lt=0, out_value=0. in_ready=1 from the first cycle after reset. In-flight pairs are discarded, including mid-stall; no partial result is emitted.
- in_valid=0 while idle → no state change other than valid bits draining.

Optional Feature:
- Macro FP_CMP_STATS_EN.
- Defined:
  - Adds input stat_clear (1) and output stat_gt_count (16).
  - Counter increments on every out_valid && out_ready with out_gt=1, saturating at 0xFFFF.
  - stat_clear=1 zeroes it; clear wins over a simultaneous increment.
  - Reset value 0.
- Undefined: ports and counter absent; all other behaviour identical.

Test Plan (EXP_W=4, MAN_W=8):
- Basic gt: A=0x301, B=0x2FF, sel_min=0, out_ready=1 → 2 cycles later out_gt=1, out_eq=0, out_lt=0, out_value=0x301.
- Negative ordering: A=0x1301, B=0x12FF, sel_min=1 → out_lt=1, out_value=0x1301.
- Signed zero: A=0x0000, B=0x1000, sel_min=0 → out_eq=1, out_value=0x0000. Swapped operands → out_eq=1, out_value=0x1000.
- Backpressure: out_ready=0, present 3 back-to-back pairs.
  - in_ready drops after 2 accepts.
  - out_* stable for 5 held cycles.
  - Raising out_ready drains all 3 results in order, 1 per cycle.
  - No loss or duplication.
- Reset mid-operation: 2 pairs in flight, rst_n=0 for 1 cycle → out_valid=0 and out_value=0 next cycle, in_ready=1. Neither pair is ever emitted.
- Stats (FP_CMP_STATS_EN):
  - 3 gt results and 1 lt result accepted → stat_gt_count=3.
  - stat_clear asserted together with a gt accept → count=0.
  - Force the count to 0xFFFF, then one more gt accept → stays 0xFFFF.
